// File: rtl/vlc_frame_sequencer.sv
// Camera-frame byte ingest: groups R,G,B bytes into pixels, tracks column/row
// over a WIDTH x HEIGHT frame and emits a thresholded pixel with frame strobes.
`timescale 1ns/1ps

module vlc_frame_sequencer #(
  parameter int WIDTH     = 180,
  parameter int HEIGHT    = 350,
  parameter int THRESHOLD = 90
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] datain,
  output logic       pix_valid,
  output logic [9:0] pix_sum,
  output logic       pix_bit,
  output logic [7:0] pix_col,
  output logic [8:0] pix_row,
  output logic       row_end,
  output logic       frame_done,
  output logic       frame_short,
  output logic       busy,
  output logic [7:0] frame_cnt
);

  typedef enum logic [1:0] {
    IDLE,
    CAPTURE,
    DRAIN
  } state_t;

  localparam logic [7:0] LAST_COL = 8'(WIDTH - 1);
  localparam logic [8:0] LAST_ROW = 9'(HEIGHT - 1);
  localparam logic [9:0] ON_LEVEL = 10'(3 * THRESHOLD);

  state_t      state;
  state_t      next_state;
  logic [1:0]  phase;
  logic [7:0]  col;
  logic [8:0]  row;
  logic [7:0]  r_hold;
  logic [7:0]  g_hold;

  logic        take_byte;
  logic        pix_fire;
  logic        last_pix;
  logic        drop;
  logic        enter_idle;
  logic [9:0]  sum_now;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (start) begin
          next_state = CAPTURE;
        end
      end
      CAPTURE: begin
        if (!start) begin
          next_state = IDLE;
        end else if (last_pix) begin
          next_state = DRAIN;
        end
      end
      DRAIN: begin
        if (!start) begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Control decode; IDLE always sits at phase 0, so its first byte lands as R.
  always_comb begin
    take_byte  = 1'b0;
    pix_fire   = 1'b0;
    last_pix   = 1'b0;
    drop       = 1'b0;
    enter_idle = 1'b0;
    case (state)
      IDLE: begin
        take_byte = start;
      end
      CAPTURE: begin
        take_byte  = start;
        pix_fire   = start && (phase == 2'd2);
        last_pix   = start && (phase == 2'd2) && (col == LAST_COL) && (row == LAST_ROW);
        drop       = !start;
        enter_idle = !start;
      end
      DRAIN: begin
        enter_idle = !start;
      end
      default: begin
        enter_idle = 1'b1;
      end
    endcase
  end

  assign sum_now = {2'b00, r_hold} + {2'b00, g_hold} + {2'b00, datain};

  // Byte phase, R/G holding and col/row position; cleared whenever a frame ends.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase  <= 2'd0;
      col    <= 8'd0;
      row    <= 9'd0;
      r_hold <= 8'd0;
      g_hold <= 8'd0;
    end else if (enter_idle || last_pix) begin
      phase  <= 2'd0;
      col    <= 8'd0;
      row    <= 9'd0;
      r_hold <= 8'd0;
      g_hold <= 8'd0;
    end else if (take_byte) begin
      case (phase)
        2'd0: begin
          r_hold <= datain;
          phase  <= 2'd1;
        end
        2'd1: begin
          g_hold <= datain;
          phase  <= 2'd2;
        end
        default: begin
          phase <= 2'd0;
          if (col == LAST_COL) begin
            col <= 8'd0;
            row <= row + 9'd1;
          end else begin
            col <= col + 8'd1;
          end
        end
      endcase
    end
  end

  // Registered pixel outputs; pix_* hold between strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_valid   <= 1'b0;
      pix_sum     <= 10'd0;
      pix_bit     <= 1'b0;
      pix_col     <= 8'd0;
      pix_row     <= 9'd0;
      row_end     <= 1'b0;
      frame_done  <= 1'b0;
      frame_short <= 1'b0;
      frame_cnt   <= 8'd0;
    end else begin
      pix_valid   <= pix_fire;
      row_end     <= pix_fire && (col == LAST_COL);
      frame_done  <= last_pix;
      frame_short <= drop;
      if (pix_fire) begin
        pix_sum <= sum_now;
        pix_bit <= (sum_now >= ON_LEVEL);
        pix_col <= col;
        pix_row <= row;
      end
      if (last_pix) begin
        frame_cnt <= frame_cnt + 8'd1;
      end
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: doc/vlc_frame_sequencer.md
# vlc_frame_sequencer

Ingest controller for the VLC receiver's camera-frame byte stream. It accepts one byte per clock while `start` is high and groups the bytes into R,G,B pixel triplets. It tracks column/row position over a WIDTH×HEIGHT frame and emits one thresholded pixel per triplet with position and frame-boundary strobes. It sits between the frame source (`start`/`datain`) and the downstream demodulation logic, and discards bytes that arrive after a frame completes or while the block is idle.

## Interface
- `WIDTH`, 180: pixels per row.
- `HEIGHT`, 350: rows per frame.
- `THRESHOLD`, 90: per-channel brightness threshold; pixel is "on" when R+G+B ≥ 3·THRESHOLD.
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  frame-active qualifier; while high, `datain` carries one valid byte per cycle.
- `datain`  in  8  stream byte, order R,G,B per pixel, row-major.
- `pix_valid`  out  1  one-cycle strobe: pixel outputs valid.
- `pix_sum`  out  10  R+G+B of the pixel (0..765).
- `pix_bit`  out  1  `pix_sum` ≥ 3·THRESHOLD.
- `pix_col`  out  8  column of the pixel, 0..WIDTH-1.
- `pix_row`  out  9  row of the pixel, 0..HEIGHT-1.
- `row_end`  out  1  with `pix_valid` on column WIDTH-1.
- `frame_done`  out  1  one-cycle pulse with the last pixel of a complete frame.
- `frame_short`  out  1  one-cycle pulse: `start` fell before the frame completed.
- `busy`  out  1  high in CAPTURE or DRAIN.
- `frame_cnt`  out  8  completed frames, wraps 255→0.

## Operation
- States: IDLE, CAPTURE, DRAIN.
- IDLE:
  - `start`=1 → accept `datain` as R of pixel (0,0) in the same cycle; go to CAPTURE.
  - `start`=0 → stay in IDLE.
- CAPTURE: each cycle with `start`=1 accepts one byte.
  - Byte phase counter runs 0→1→2→0.
  - At phase 2 the sum is formed as R+G+B, zero-extended to 10 bits with no saturation, and presented with the current col/row.
  - Then col increments; at WIDTH-1 it wraps to 0 and row increments.
- Last byte: the B byte of (WIDTH-1, HEIGHT-1) → `frame_done`, `frame_cnt`+1, go to DRAIN.
- DRAIN: all bytes are ignored while `start`=1. `start`=0 → IDLE. A new frame requires `start` to go low then high.
- CAPTURE with `start`=0 (early drop):
  - pulse `frame_short`; discard any partial pixel;
  - clear phase/col/row; go to IDLE;
  - `frame_cnt` unchanged.
- Counters (phase, col, row) are cleared on every entry to IDLE.
- Start of frame and early drop never coincide in one cycle; from IDLE, `start`=1 always begins a fresh frame.

## Timing
- Reset (async, `rst_n`=0): state IDLE.
  - All outputs 0: `pix_valid`, `pix_sum`, `pix_bit`, `pix_col`, `pix_row`, `row_end`, `frame_done`, `frame_short`, `busy`, `frame_cnt`.
  - Internal counters and R/G holding registers are also 0.
- Outputs are registered; latency is 1 cycle from the clock edge sampling the B byte to `pix_valid`.
- `frame_done` and `row_end` coincide with the final `pix_valid`. `frame_short` is asserted 1 cycle after the edge that samples `start`=0.
- Strobe widths:
  - `pix_valid` is high for exactly 1 cycle per pixel, at most once every 3 cycles.
  - `frame_done` and `frame_short` are high for exactly 1 cycle.
- `busy` rises 1 cycle after the first accepted byte and falls 1 cycle after `start` is sampled low.
- `pix_*` hold their last values between strobes.
- Reset mid-frame: immediate return to IDLE, outputs 0, and no `frame_short`.
- Throughput: sustained 1 byte per clock with no back-pressure. The source must not pause within a frame; a pause ends the frame as short.

## Test plan
- WIDTH=4, HEIGHT=2, THRESHOLD=90. Feed 24 bytes all 0x5A with `start` high -> 8 `pix_valid`, each `pix_sum`=270 and `pix_bit`=1; `row_end` at col 3 for rows 0 and 1; `frame_done` with pixel (3,1); `frame_cnt`=1.
- Pixel bytes 0x59,0x5A,0x5A -> `pix_sum`=269, `pix_bit`=0. Bytes 0xFF×3 -> `pix_sum`=765, no overflow.
- Same frame with `start` held high for 30 bytes -> the 6 extra bytes produce no `pix_valid`. `start` low then high -> new frame at (0,0), `frame_cnt`=2.
- `start` falls after 10 bytes -> 3 `pix_valid` (cols 0-2, row 0), then `frame_short` pulse, no `frame_done`, `frame_cnt` unchanged. Next frame starts at (0,0).
- `rst_n` pulsed low at byte 13 -> all outputs 0 immediately, no `frame_short`. A following full frame decodes correctly from (0,0).
- Default parameters, 256 back-to-back full frames with 189000 bytes each -> 256 `frame_done` pulses; `frame_cnt` wraps to 0; `pix_row` max 349; `pix_col` max 179.
